// File: rtl/nav_msg_bit_gen.sv
// Navigation-message bit source: buffers bytes in a small FIFO and shifts them
// out MSB-first, one bit every EPOCHS_PER_BIT code epochs.
module nav_msg_bit_gen #(
  parameter int unsigned EPOCHS_PER_BIT = 20,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic        IDLE_BIT       = 1'b0
) (
  input  logic                          clk_in,
  input  logic                          rst_in_n,
  input  logic                          ena_in,
  input  logic                          epoch_in,
  input  logic                          byte_valid_in,
  input  logic [7:0]                    byte_in,
  output logic                          byte_ready_out,
  output logic                          msg_out,
  output logic                          bit_strobe_out,
  output logic                          underrun_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(EPOCHS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] epoch_cnt;
  logic [2:0]       bits_left;
  logic [7:0]       shift_q;

  logic             push;
  logic             pop;
  logic             boundary;
  logic             fifo_empty;
  logic [7:0]       head;

  // Handshake and boundary decode, all from pre-edge registered state
  always_comb begin
    byte_ready_out = (level != LVL_FULL);
    fifo_empty     = (level == '0);
    push           = byte_valid_in && byte_ready_out;
    boundary       = ena_in && epoch_in && (epoch_cnt == '0);
    pop            = boundary && (bits_left == 3'd0) && !fifo_empty;
    head           = mem[rd_ptr];
  end

  assign fifo_level_out = level;

  // Storage array needs no reset: the pointers and level define validity
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= byte_in;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves level unchanged
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Epoch divider and serialiser; disabling drops any byte in flight
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      epoch_cnt      <= '0;
      bits_left      <= '0;
      shift_q        <= '0;
      msg_out        <= IDLE_BIT;
      bit_strobe_out <= 1'b0;
      underrun_out   <= 1'b0;
    end else if (!ena_in) begin
      epoch_cnt      <= '0;
      bits_left      <= '0;
      shift_q        <= '0;
      msg_out        <= IDLE_BIT;
      bit_strobe_out <= 1'b0;
    end else begin
      bit_strobe_out <= boundary;
      if (epoch_in) begin
        epoch_cnt <= (epoch_cnt == CNT_MAX) ? '0 : epoch_cnt + CNT_W'(1);
      end
      if (boundary) begin
        if (bits_left != 3'd0) begin
          msg_out   <= shift_q[7];
          shift_q   <= {shift_q[6:0], 1'b0};
          bits_left <= bits_left - 3'd1;
        end else if (!fifo_empty) begin
          msg_out      <= head[7];
          shift_q      <= {head[6:0], 1'b0};
          bits_left    <= 3'd7;
          underrun_out <= 1'b0;
        end else begin
          msg_out      <= IDLE_BIT;
          underrun_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nav_msg_bit_gen.sv
// Bench for nav_msg_bit_gen: directed scenarios plus randomized traffic, all
// checked against a queue-based message model.
module tb_nav_msg_bit_gen;

  localparam int unsigned EPB   = 3;
  localparam int unsigned DEPTH = 4;
  localparam logic        IDLE  = 1'b0;

  logic       clk_in = 1'b0;
  logic       rst_in_n;
  logic       ena_in;
  logic       epoch_in;
  logic       byte_valid_in;
  logic [7:0] byte_in;
  logic       byte_ready_out;
  logic       msg_out;
  logic       bit_strobe_out;
  logic       underrun_out;
  logic [2:0] fifo_level_out;

  int errors = 0;
  int checks = 0;

  // Reference model: byte queue, pending-bit queue, epoch phase
  logic [7:0] mq [$];
  logic       bq [$];
  int         ecnt;
  logic       m_msg;
  logic       m_strobe;
  logic       m_under;
  logic       rx [$];

  nav_msg_bit_gen #(
    .EPOCHS_PER_BIT (EPB),
    .FIFO_DEPTH     (DEPTH),
    .IDLE_BIT       (IDLE)
  ) dut (
    .clk_in         (clk_in),
    .rst_in_n       (rst_in_n),
    .ena_in         (ena_in),
    .epoch_in       (epoch_in),
    .byte_valid_in  (byte_valid_in),
    .byte_in        (byte_in),
    .byte_ready_out (byte_ready_out),
    .msg_out        (msg_out),
    .bit_strobe_out (bit_strobe_out),
    .underrun_out   (underrun_out),
    .fifo_level_out (fifo_level_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    bq.delete();
    ecnt     = 0;
    m_msg    = IDLE;
    m_strobe = 1'b0;
    m_under  = 1'b0;
  endtask

  task automatic model_edge();
    logic [7:0] b;
    bit push_ok;
    push_ok = byte_valid_in && (mq.size() < DEPTH);
    if (!ena_in) begin
      ecnt = 0;
      bq.delete();
      m_msg    = IDLE;
      m_strobe = 1'b0;
    end else begin
      m_strobe = 1'b0;
      if (epoch_in) begin
        if (ecnt == 0) begin
          m_strobe = 1'b1;
          if (bq.size() > 0) begin
            m_msg = bq.pop_front();
          end else if (mq.size() > 0) begin
            b = mq.pop_front();
            for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
            m_msg   = bq.pop_front();
            m_under = 1'b0;
          end else begin
            m_msg   = IDLE;
            m_under = 1'b1;
          end
        end
        ecnt = (ecnt + 1) % EPB;
      end
    end
    if (push_ok) mq.push_back(byte_in);
  endtask

  task automatic check_model();
    check("msg", 32'(msg_out), 32'(m_msg));
    check("strobe", 32'(bit_strobe_out), 32'(m_strobe));
    check("underrun", 32'(underrun_out), 32'(m_under));
    check("level", 32'(fifo_level_out), 32'(mq.size()));
    check("ready", 32'(byte_ready_out), 32'(mq.size() < DEPTH));
  endtask

  task automatic step(input logic e, input logic ep, input logic v, input logic [7:0] d);
    @(negedge clk_in);
    ena_in        = e;
    epoch_in      = ep;
    byte_valid_in = v;
    byte_in       = d;
    @(posedge clk_in);
    model_edge();
    #1;
    if (bit_strobe_out) rx.push_back(msg_out);
    check_model();
  endtask

  // One full message bit: EPB epochs, each followed by idle cycles
  task automatic run_bit();
    for (int k = 0; k < int'(EPB); k++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in_n      = 1'b0;
    ena_in        = 1'b0;
    epoch_in      = 1'b0;
    byte_valid_in = 1'b0;
    byte_in       = 8'h00;
    model_reset();
    #1;
    check_model();
    @(negedge clk_in);
    rst_in_n = 1'b1;
    rx.delete();
  endtask

  function automatic logic [7:0] rx_byte(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = rx[base+i];
    return r;
  endfunction

  initial begin
    logic [7:0] burst [5];
    int pct;
    rst_in_n = 1'b0;
    ena_in = 1'b0; epoch_in = 1'b0; byte_valid_in = 1'b0; byte_in = 8'h00;
    model_reset();

    // Basic serialisation of 0xA5, then underrun and recovery
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'hA5);
    repeat (8) run_bit();
    check("a5_bits", 32'(rx.size()), 32'd8);
    if (rx.size() == 8) check("a5_byte", 32'(rx_byte(0)), 32'hA5);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("bit9_idle", 32'(msg_out), 32'(IDLE));
    check("bit9_underrun", 32'(underrun_out), 32'd1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k < int'(EPB); k++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
    end
    step(1'b1, 1'b0, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("ff_msg", 32'(msg_out), 32'd1);
    check("ff_underrun_clr", 32'(underrun_out), 32'd0);

    // Overfill: fifth byte dropped
    do_reset();
    burst[0] = 8'h12; burst[1] = 8'hC3; burst[2] = 8'h7E; burst[3] = 8'h81; burst[4] = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, burst[i]);
      if (i == 3) check("full_ready", 32'(byte_ready_out), 32'd0);
    end
    check("full_level", 32'(fifo_level_out), 32'd4);
    repeat (32) run_bit();
    check("burst_bits", 32'(rx.size()), 32'd32);
    if (rx.size() == 32) begin
      for (int i = 0; i < 4; i++) check("burst_byte", 32'(rx_byte(8*i)), 32'(burst[i]));
    end

    // Disable mid-byte discards the in-flight byte
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 1'b1, 8'h81);
    repeat (3) run_bit();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("dis_msg", 32'(msg_out), 32'(IDLE));
    check("dis_level", 32'(fifo_level_out), 32'd1);
    rx.delete();
    repeat (8) run_bit();
    check("reen_bits", 32'(rx.size()), 32'd8);
    if (rx.size() == 8) check("reen_byte", 32'(rx_byte(0)), 32'h81);

    // Push on the boundary edge with an empty FIFO
    do_reset();
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    check("bnd_msg", 32'(msg_out), 32'(IDLE));
    check("bnd_underrun", 32'(underrun_out), 32'd1);
    check("bnd_level", 32'(fifo_level_out), 32'd1);
    for (int k = 1; k < int'(EPB); k++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 8'h00);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("bnd_next_strobe", 32'(bit_strobe_out), 32'd1);
    check("bnd_next_msg", 32'(msg_out), 32'd0);
    check("bnd_next_level", 32'(fifo_level_out), 32'd0);

    // Asynchronous reset mid-bit with bytes queued
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'hF0);
    step(1'b1, 1'b0, 1'b1, 8'h11);
    step(1'b1, 1'b0, 1'b1, 8'h22);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("pre_rst_msg", 32'(msg_out), 32'd1);
    check("pre_rst_level", 32'(fifo_level_out), 32'd2);
    @(negedge clk_in);
    #2;
    rst_in_n = 1'b0;
    #1;
    check("arst_msg", 32'(msg_out), 32'(IDLE));
    check("arst_strobe", 32'(bit_strobe_out), 32'd0);
    check("arst_underrun", 32'(underrun_out), 32'd0);
    check("arst_level", 32'(fifo_level_out), 32'd0);
    check("arst_ready", 32'(byte_ready_out), 32'd1);
    do_reset();

    // Randomized traffic alternating heavy and sparse writes
    for (int blk = 0; blk < 8; blk++) begin
      pct = (blk % 2 == 0) ? 30 : 1;
      for (int n = 0; n < 400; n++) begin
        step(($urandom_range(0, 29) != 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 99) < pct),
             8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nav_msg_bit_gen.md
Name: nav_msg_bit_gen

Overview:
- Navigation-message bit source that drives the core's msg_in input.
- Accepts message bytes through a valid/ready byte interface, fed by the UART register path, and buffers them in a small FIFO.
- Serialises the bytes MSB-first at one bit per EPOCHS_PER_BIT C/A-code epochs. Epochs are marked by the core's start_out pulse, so every data-bit edge is aligned to a code epoch (50 bps at 1 ms epochs).

Parameters:
EPOCHS_PER_BIT, 20, C/A epochs per message bit; legal range 1..255.
FIFO_DEPTH, 4, byte FIFO depth; must be a power of 2, ≥2.
IDLE_BIT, 1'b0, value driven on msg_out when disabled or when the FIFO underruns.

Ports:
clk_in  input  1  system clock
rst_in_n  input  1  reset, asynchronous, active-low
ena_in  input  1  general enable (from the register bank)
epoch_in  input  1  single-cycle C/A epoch pulse (core start_out)
byte_valid_in  input  1  byte write request
byte_in  input  8  message byte; bit 7 is transmitted first
byte_ready_out  input→output  1  FIFO can accept a byte (output)
msg_out  output  1  current message bit, to the core's msg_in
bit_strobe_out  output  1  one-cycle pulse when msg_out takes a new bit
underrun_out  output  1  sticky flag: a bit boundary found no data
fifo_level_out  output  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO

Behaviour:
- One clock domain: clk_in.
- Reset: rst_in_n is asynchronous and active-low.
- Reset values:
  - msg_out=IDLE_BIT, bit_strobe_out=0, underrun_out=0.
  - FIFO empty, fifo_level_out=0, byte_ready_out=1.
  - epoch_cnt=0, bits_left=0, shift register=0.
  - Reset mid-operation discards all FIFO and shift contents.
- FIFO write:
  - byte_ready_out = (level != FIFO_DEPTH), combinational from the registered level.
  - A byte is pushed on a clock edge where byte_valid_in && byte_ready_out.
  - Pushes are accepted regardless of ena_in.
  - byte_valid_in while the FIFO is full is ignored. The byte is dropped, with no error flag.
- Epoch counter:
  - Counts only when ena_in=1: on each epoch_in, epoch_cnt <= (epoch_cnt==EPOCHS_PER_BIT-1) ? 0 : epoch_cnt+1.
  - A bit boundary is an epoch_in pulse seen with ena_in=1 and epoch_cnt==0.
  - The first epoch after enable is therefore a boundary.
- At a bit boundary, all outputs are registered, so msg_out and bit_strobe_out change one cycle after the epoch_in cycle:
  - bits_left>0: msg_out <= shift[7]; shift <= shift<<1; bits_left--.
  - bits_left==0 and FIFO not empty: pop the head byte; msg_out <= byte[7]; shift <= byte<<1; bits_left <= 7; underrun_out <= 0.
  - bits_left==0 and FIFO empty: msg_out <= IDLE_BIT; underrun_out <= 1.
  - bit_strobe_out <= 1 in every case above; otherwise bit_strobe_out=0.
- Push and pop on the same edge:
  - The level is unchanged.
  - The pop uses the pre-edge state. A push into an empty FIFO on a boundary edge therefore yields an idle bit, and the byte is stored.
- ena_in=0, checked synchronously each cycle:
  - epoch_cnt<=0, bits_left<=0; any in-flight byte is discarded.
  - msg_out<=IDLE_BIT, bit_strobe_out<=0.
  - FIFO contents and underrun_out are retained.
  - epoch_in is ignored.
- Pointer wrap-around: rd/wr pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The level counter distinguishes full from empty.
- Latency: a byte pushed into an empty FIFO with bits_left==0 appears on msg_out one cycle after the next bit boundary.

Test Plan:
1. Reset then push 0xA5 with ena_in=1, EPOCHS_PER_BIT=20, epoch_in every 100 cycles.
   - msg_out follows 1,0,1,0,0,1,0,1, each bit held for 20 epochs.
   - bit_strobe_out fires one cycle after epochs 0, 20, 40 …
2. Run 8 bits past the last byte.
   - Boundary 9 drives IDLE_BIT and sets underrun_out=1.
   - Then push 0xFF: the next boundary gives msg_out=1 and clears underrun_out.
3. Push 5 bytes back-to-back with FIFO_DEPTH=4 and no epochs.
   - byte_ready_out drops after the 4th push.
   - The 5th byte is dropped; fifo_level_out=4.
   - The transmitted sequence contains only bytes 1–4.
4. Drop ena_in mid-byte (after 3 bits of 0x3C).
   - msg_out=IDLE_BIT next cycle; the FIFO level is unchanged.
   - On re-enable, the next byte starts at the first epoch; the remainder of 0x3C is never sent.
5. Assert byte_valid_in on the exact boundary cycle with the FIFO empty.
   - The idle bit is emitted and underrun_out=1.
   - fifo_level_out=1; the byte is sent at the following boundary.
6. Assert rst_in_n=0 asynchronously mid-bit, with 2 bytes queued.
   - All outputs take their reset values immediately, without waiting for a clock edge.
   - fifo_level_out=0 and byte_ready_out=1.
